// File: rtl/vga_timing_pkg.sv
// Package: vga_timing_pkg
// Purpose: shared 640x480@60 Hz VGA timing constants, sync window bounds,
//          9-bit RRRGGGBBB pixel field slices, the delay-line payload type
//          and the colour-bar helper used by vga_display_ctrl.
// Optional feature macro: VGA_TEST_PATTERN_EN (bar_pixel is only used then).
package vga_timing_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;

    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    // Sync windows are half-open: [START, END)
    localparam int unsigned HS_START  = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END    = HS_START + H_SYNC;
    localparam int unsigned VS_START  = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END    = VS_START + V_SYNC;

    localparam int unsigned PIX_R_HI  = 8;
    localparam int unsigned PIX_R_LO  = 6;
    localparam int unsigned PIX_G_HI  = 5;
    localparam int unsigned PIX_G_LO  = 3;
    localparam int unsigned PIX_B_HI  = 2;
    localparam int unsigned PIX_B_LO  = 0;

    typedef struct packed {
        logic valid;
        logic hs;
        logic vs;
    } sync_t;

    // Idle delay-line content: blank, both syncs inactive (high)
    localparam sync_t SYNC_IDLE = '{valid: 1'b0, hs: 1'b1, vs: 1'b1};

    function automatic logic [8:0] bar_pixel(input logic [2:0] b);
        return {{3{b[2]}}, {3{b[1]}}, {3{b[0]}}};
    endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Module: sync_delay_line
// Purpose: DEPTH-stage shift register of WIDTH bits with asynchronous
//          active-low clear to RST_VAL.
// Ports:
//   i_clk    - clock
//   i_rst_n  - asynchronous active-low clear
//   i_d      - data into stage 0
//   o_q      - data out of the last stage (DEPTH cycles later)
module sync_delay_line #(
    parameter int unsigned      WIDTH   = 3,
    parameter int unsigned      DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_stage[i] <= RST_VAL;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/vga_display_ctrl.sv
// Module: vga_display_ctrl
// Purpose: VGA timing master and pixel sink. Produces h_cnt/v_cnt for the
//          pixel generators, takes their pixel PIPE_DELAY cycles later,
//          re-aligns sync/blanking to it and drives registered VGA pins
//          (pin latency PIPE_DELAY+1 from the counter value).
// Optional feature macro: VGA_TEST_PATTERN_EN - test_mode=1 replaces
//          pixel_in with colour bars taken from h_cnt[8:6].
// Ports:
//   clk_25MHz   - pixel clock
//   rst         - asynchronous active-low reset
//   pixel_in    - composited pixel {R[2:0],G[2:0],B[2:0]}
//   test_mode   - colour-bar select (optional feature only)
//   h_cnt/v_cnt - current column 0..799 / line 0..524
//   frame_start - one-cycle pulse when counters read (0,0) after a wrap
//   vgaRed/vgaGreen/vgaBlue - registered colour pins
//   hsync/vsync - registered active-low syncs
module vga_display_ctrl #(
    parameter int unsigned H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
    parameter int unsigned H_FRONT    = vga_timing_pkg::H_FRONT,
    parameter int unsigned H_SYNC     = vga_timing_pkg::H_SYNC,
    parameter int unsigned H_BACK     = vga_timing_pkg::H_BACK,
    parameter int unsigned V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
    parameter int unsigned V_FRONT    = vga_timing_pkg::V_FRONT,
    parameter int unsigned V_SYNC     = vga_timing_pkg::V_SYNC,
    parameter int unsigned V_BACK     = vga_timing_pkg::V_BACK,
    parameter int unsigned PIPE_DELAY = 1
) (
    input  logic       clk_25MHz,
    input  logic       rst,
    input  logic [8:0] pixel_in,
    input  logic       test_mode,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       frame_start,
    output logic [2:0] vgaRed,
    output logic [2:0] vgaGreen,
    output logic [2:0] vgaBlue,
    output logic       hsync,
    output logic       vsync
);

    import vga_timing_pkg::*;

    localparam logic [9:0] H_VIS       = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS       = 10'(V_VISIBLE);
    localparam logic [9:0] H_LAST      = 10'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST      = 10'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] HSYNC_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HSYNC_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VSYNC_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VSYNC_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] r_h_cnt;
    logic [9:0] r_v_cnt;
    logic       r_frame_start;
    logic       r_hsync;
    logic       r_vsync;
    logic [8:0] r_rgb;

    sync_t      w_sync0;
    sync_t      w_sync_d;
    logic [8:0] w_pixel;

    always_ff @(posedge clk_25MHz or negedge rst) begin
        if (!rst) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_frame_start <= 1'b0;
        end else begin
            // Counters land on (0,0) on this edge exactly when they leave the last position
            r_frame_start <= (r_h_cnt == H_LAST) && (r_v_cnt == V_LAST);
            if (r_h_cnt == H_LAST) begin
                r_h_cnt <= '0;
                r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 10'd1;
            end else begin
                r_h_cnt <= r_h_cnt + 10'd1;
            end
        end
    end

    always_comb begin
        w_sync0       = SYNC_IDLE;
        w_sync0.valid = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
        w_sync0.hs    = !((r_h_cnt >= HSYNC_START) && (r_h_cnt < HSYNC_END));
        w_sync0.vs    = !((r_v_cnt >= VSYNC_START) && (r_v_cnt < VSYNC_END));
    end

    sync_delay_line #(
        .WIDTH   ($bits(sync_t)),
        .DEPTH   (PIPE_DELAY),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .i_clk   (clk_25MHz),
        .i_rst_n (rst),
        .i_d     (w_sync0),
        .o_q     (w_sync_d)
    );

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] w_bar_d;

    // Bar index travels with valid/hs/vs so it meets the same pixel slot
    sync_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE_DELAY),
        .RST_VAL (3'b000)
    ) u_bar_delay (
        .i_clk   (clk_25MHz),
        .i_rst_n (rst),
        .i_d     (r_h_cnt[8:6]),
        .o_q     (w_bar_d)
    );

    assign w_pixel = test_mode ? bar_pixel(w_bar_d) : pixel_in;
`else
    logic w_unused_test_mode;
    assign w_unused_test_mode = test_mode;
    assign w_pixel            = pixel_in;
`endif

    always_ff @(posedge clk_25MHz or negedge rst) begin
        if (!rst) begin
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
            r_rgb   <= '0;
        end else begin
            r_hsync <= w_sync_d.hs;
            r_vsync <= w_sync_d.vs;
            r_rgb   <= w_sync_d.valid ? w_pixel : '0;
        end
    end

    assign h_cnt       = r_h_cnt;
    assign v_cnt       = r_v_cnt;
    assign frame_start = r_frame_start;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign vgaRed      = r_rgb[PIX_R_HI:PIX_R_LO];
    assign vgaGreen    = r_rgb[PIX_G_HI:PIX_G_LO];
    assign vgaBlue     = r_rgb[PIX_B_HI:PIX_B_LO];

endmodule

// File: tb/tb_vga_display_ctrl.sv
// Testbench: tb_vga_display_ctrl
// DUT A: default 640x480 timing, PIPE_DELAY=1.
// DUT B: shrunken timing (24x10 total), PIPE_DELAY=3, checked every cycle
//        against an index-based model so whole frames fit a short run.
module tb_vga_display_ctrl;

    logic clk;
    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    // ---------------- DUT A ----------------
    logic       rst_a, test_mode_a, fs_a, hs_a, vs_a;
    logic [8:0] pixel_in_a;
    logic [9:0] h_a, v_a;
    logic [2:0] r_a, g_a, b_a;

    vga_display_ctrl #(.PIPE_DELAY(1)) u_dut_a (
        .clk_25MHz   (clk),
        .rst         (rst_a),
        .pixel_in    (pixel_in_a),
        .test_mode   (test_mode_a),
        .h_cnt       (h_a),
        .v_cnt       (v_a),
        .frame_start (fs_a),
        .vgaRed      (r_a),
        .vgaGreen    (g_a),
        .vgaBlue     (b_a),
        .hsync       (hs_a),
        .vsync       (vs_a)
    );

    // ---------------- DUT B ----------------
    localparam int BH = 24;   // 16 + 2 + 4 + 2
    localparam int BV = 10;   // 6 + 1 + 2 + 1
    localparam int BF = BH * BV;

    logic       rst_b, test_mode_b, fs_b, hs_b, vs_b;
    logic [8:0] pixel_in_b;
    logic [9:0] h_b, v_b;
    logic [2:0] r_b, g_b, b_b;

    vga_display_ctrl #(
        .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(4), .H_BACK(2),
        .V_VISIBLE(6),  .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .PIPE_DELAY(3)
    ) u_dut_b (
        .clk_25MHz   (clk),
        .rst         (rst_b),
        .pixel_in    (pixel_in_b),
        .test_mode   (test_mode_b),
        .h_cnt       (h_b),
        .v_cnt       (v_b),
        .frame_start (fs_b),
        .vgaRed      (r_b),
        .vgaGreen    (g_b),
        .vgaBlue     (b_b),
        .hsync       (hs_b),
        .vsync       (vs_b)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    task automatic wait_h_a(input logic [9:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (h_a == target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Expected DUT B state at negedge k after reset release:
    // {h_cnt, v_cnt, frame_start, hsync, vsync, rgb}; pins lag counters by 4.
    function automatic logic [31:0] exp_b(input int k);
        int c, l, pc, pl;
        logic [9:0] eh, ev;
        logic efs, ehs, evs;
        logic [8:0] rgb;
        c   = k % BH;
        l   = (k / BH) % BV;
        eh  = 10'(c);
        ev  = 10'(l);
        efs = (k > 0) && (k % BF == 0);
        ehs = 1'b1;
        evs = 1'b1;
        rgb = '0;
        if (k >= 4) begin
            pc  = (k - 4) % BH;
            pl  = ((k - 4) / BH) % BV;
            ehs = !(pc >= 18 && pc < 22);
            evs = !(pl >= 7 && pl < 9);
            rgb = (pc < 16 && pl < 6) ? 9'(pc) : 9'd0;
        end
        return {eh, ev, efs, ehs, evs, rgb};
    endfunction

    function automatic logic [31:0] act_b();
        return {h_b, v_b, fs_b, hs_b, vs_b, r_b, g_b, b_b};
    endfunction

    typedef struct {
        logic [9:0] col;
        logic [8:0] pix;
        logic [8:0] exp_rgb;
        logic       exp_hs;
    } vec_t;

    vec_t vecs[8];

    initial begin
        bit ok;
        int n, w, first_hs, vs_low, fs_cnt, fs_first, fs_second;

        vecs[0] = '{col: 10'd0,   pix: 9'h1FF,       exp_rgb: 9'h1FF,       exp_hs: 1'b1};
        vecs[1] = '{col: 10'd100, pix: 9'b101010011, exp_rgb: 9'b101010011, exp_hs: 1'b1};
        vecs[2] = '{col: 10'd639, pix: 9'h1FF,       exp_rgb: 9'h1FF,       exp_hs: 1'b1};
        vecs[3] = '{col: 10'd640, pix: 9'h1FF,       exp_rgb: 9'h000,       exp_hs: 1'b1};
        vecs[4] = '{col: 10'd655, pix: 9'h1FF,       exp_rgb: 9'h000,       exp_hs: 1'b1};
        vecs[5] = '{col: 10'd656, pix: 9'h1FF,       exp_rgb: 9'h000,       exp_hs: 1'b0};
        vecs[6] = '{col: 10'd751, pix: 9'h0AA,       exp_rgb: 9'h000,       exp_hs: 1'b0};
        vecs[7] = '{col: 10'd752, pix: 9'h0AA,       exp_rgb: 9'h000,       exp_hs: 1'b1};

        rst_a = 1'b0; rst_b = 1'b0;
        test_mode_a = 1'b0; test_mode_b = 1'b0;
        pixel_in_a = '0; pixel_in_b = '0;

        // ---------------- DUT A: reset and first line ----------------
        repeat (3) @(negedge clk);
        check("a_reset", {h_a, v_a, fs_a, hs_a, vs_a, r_a, g_a, b_a},
              {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 9'd0});
        rst_a = 1'b1;
        #1 check("a_hold_h", {22'd0, h_a}, 32'd0);

        n = 0;
        ok = 1'b0;
        while (n < 2000) begin
            @(negedge clk);
            n++;
            if (n == 1) check("a_count1", {22'd0, h_a}, 32'd1);
            if (n == 2) check("a_count2", {22'd0, h_a}, 32'd2);
            if (!hs_a) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("a_first_hsync");
        else begin
            check("a_first_hsync", n, 658);
            w = 1;
            while (!hs_a && w < 200) begin
                @(negedge clk);
                if (!hs_a) w++;
            end
            check("a_hsync_width", w, 96);
        end

        // ---------------- DUT A: table of column vectors ----------------
        for (int i = 0; i < 8; i++) begin
            wait_h_a(vecs[i].col + 10'd1, ok);
            if (!ok) timeout("a_vec_wait");
            else begin
                pixel_in_a = vecs[i].pix;
                @(negedge clk);
                pixel_in_a = '0;
                check($sformatf("a_vec%0d_rgb", i), {23'd0, r_a, g_a, b_a}, {23'd0, vecs[i].exp_rgb});
                check($sformatf("a_vec%0d_hs", i), {31'd0, hs_a}, {31'd0, vecs[i].exp_hs});
            end
        end

`ifdef VGA_TEST_PATTERN_EN
        test_mode_a = 1'b1;
        pixel_in_a  = '0;
        for (int i = 0; i < 4; i++) begin
            logic [9:0] bc [4];
            logic [8:0] be [4];
            bc = '{10'd0, 10'd64, 10'd448, 10'd700};
            be = '{9'h000, 9'h007, 9'h1FF, 9'h000};
            wait_h_a(bc[i] + 10'd1, ok);
            if (!ok) timeout("a_bar_wait");
            else begin
                @(negedge clk);
                check($sformatf("a_bar%0d", i), {23'd0, r_a, g_a, b_a}, {23'd0, be[i]});
            end
        end
        test_mode_a = 1'b0;
`endif

        // ---------------- DUT B: PIPE_DELAY=3, two frames ----------------
        check("b_reset", act_b(), exp_b(0));
        rst_b = 1'b1;
        pixel_in_b = '0;
        #1 check("b_k0", act_b(), exp_b(0));
        first_hs = -1; vs_low = 0; fs_cnt = 0; fs_first = -1; fs_second = -1;
        for (int k = 1; k <= 2 * BF + 82; k++) begin
            @(negedge clk);
            check($sformatf("b_k%0d", k), act_b(), exp_b(k));
            if (!hs_b && first_hs < 0) first_hs = k;
            if (!vs_b) vs_low++;
            if (fs_b) begin
                fs_cnt++;
                if (fs_first < 0) fs_first = k;
                else if (fs_second < 0) fs_second = k;
            end
            pixel_in_b = (k >= 3) ? 9'((k - 3) % BH) : 9'd0;
        end
        // HS_START(18) + 3 delay + 1 out: two cycles later than with PIPE_DELAY=1
        check("b_first_hsync", first_hs, 22);
        check("b_vsync_low", vs_low, 2 * 2 * BH);
        check("b_fs_count", fs_cnt, 2);
        check("b_fs_period", fs_second - fs_first, BF);

        // Mid-frame reset at counters (10,3), asynchronous
        check("b_pre_reset_pos", {12'd0, h_b, v_b}, {12'd0, 10'd10, 10'd3});
        #5 rst_b = 1'b0;
        #1 check("b_midreset", act_b(), exp_b(0));
        @(negedge clk);
        rst_b = 1'b1;
        pixel_in_b = '0;
        fs_first = -1;
        for (int k = 1; k <= BF + 5; k++) begin
            @(negedge clk);
            if (fs_b && fs_first < 0) fs_first = k;
            if (k < 30) check($sformatf("b_restart_k%0d", k), act_b(), exp_b(k));
            pixel_in_b = (k >= 3) ? 9'((k - 3) % BH) : 9'd0;
        end
        check("b_fs_after_reset", fs_first, BF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
